scroll_rate_ctrl: RTL
=====================

Name: scroll_rate_ctrl

Overview:
- Upstream timing stage for the 7-segment scrolling-message display.
- Produces the single-cycle scroll strobe that advances the message shift chain.
- Replaces the fixed 1 Hz divider with a rate adjustable at run time from two pushbuttons: one halves the period, the other doubles it.
- Also provides a pause input and exports the current speed level for LEDs.

Parameters:
- MIN_PERIOD, 3125000: scroll period in clock cycles at level 0 (1/16 s at 50 MHz).
- NUM_LEVELS, 8: number of speed levels, 0 (fastest) .. NUM_LEVELS-1 (slowest).
- DEFAULT_LEVEL, 4: level loaded at reset (1 s period at defaults).
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before a button level is accepted (10 ms).
- CNT_W, 32: period counter width. MIN_PERIOD << (NUM_LEVELS-1) must be less than 2^CNT_W.

Ports:
- CLOCK_50, in, 1: system clock, all logic on the rising edge.
- Resetn, in, 1: asynchronous active-low reset.
- faster_n, in, 1: raw active-low pushbutton, asynchronous to the clock. A press decrements the level.
- slower_n, in, 1: raw active-low pushbutton, asynchronous. A press increments the level.
- pause, in, 1: synchronous level input. While high, the period counter holds and no tick is issued.
- tick, out, 1: registered one-cycle scroll strobe.
- level, out, 3: current speed level (clog2(NUM_LEVELS) wide).

Behaviour:
- Reset (Resetn=0, asynchronous):
  - tick=0, level=DEFAULT_LEVEL, period counter=0.
  - Synchronizer and debounced button states = 1 (released).
  - Debounce counters = 0.
- Button path, identical for each button:
  - Two-flop synchronizer.
  - Debounce: a counter restarts at 0 whenever the synchronized value differs from the accepted state. The accepted state flips once the difference has persisted DEBOUNCE_CYCLES consecutive cycles.
  - A press event is a one-cycle pulse when the accepted state goes 1->0. Release generates nothing.
  - Latency from a clean input edge to the press pulse: 2 + DEBOUNCE_CYCLES cycles.
  - Bounces shorter than DEBOUNCE_CYCLES produce no event.
- Level update, in the cycle after a press pulse:
  - faster: level = level-1, saturating at 0.
  - slower: level = level+1, saturating at NUM_LEVELS-1.
  - Both press pulses in the same cycle: level unchanged, no counter restart.
  - Saturated press (no change in level): no counter restart.
- Period: P = MIN_PERIOD << level.
- Counter:
  - Counts 0..P-1 while pause=0.
  - When the counter equals P-1, it wraps to 0 and tick=1 in the next cycle (registered). tick is high for exactly one cycle.
  - First tick after reset is asserted P cycles after Resetn deasserts.
- Level change: the counter clears to 0 in the same cycle the level updates. The next tick comes a full new P later, and no tick is issued from the old period.
  - Level change coinciding with counter==P-1: the restart wins and no tick is issued.
- Pause:
  - pause=1 freezes the counter and forces tick=0.
  - Button presses are still processed and may change the level; a level change still clears the counter.
  - On pause=0, counting resumes from the held value.
- tick never asserts in two consecutive cycles (P >= 2 required; MIN_PERIOD >= 2).
- Reset mid-count or mid-debounce: all state returns immediately to the reset values. A button held down through reset deassertion generates a press once debounced (accepted state starts at 1).

Test Plan (bench params: MIN_PERIOD=4, NUM_LEVELS=8, DEFAULT_LEVEL=2, DEBOUNCE_CYCLES=3):
- Reset release, buttons idle:
  - level=2.
  - tick pulses every 16 cycles, first pulse 16 cycles after Resetn rises.
  - 1 cycle wide.
- Clean faster press held 10 cycles:
  - level 2->1 exactly 6 cycles after the input falls (2 sync + 3 debounce + 1 update).
  - Counter restarts; next tick 8 cycles after the level update, then every 8 cycles.
- slower_n glitch 0 for 2 cycles, then back to 1:
  - No level change.
  - tick cadence unchanged at 16.
- Saturation:
  - 3 faster presses from level 2 -> level 0 after the 2nd press; the 3rd is ignored and the counter is not restarted.
  - 8 slower presses from level 0 -> level 7 (period 512); extra presses keep level 7.
- Simultaneous presses, both buttons falling in the same cycle: level unchanged, tick period unchanged.
- Pause:
  - Assert pause for 20 cycles at counter=5: no tick during pause; the tick occurs 11 cycles after deassertion (level 2).
  - A faster press during pause sets level 1; after unpause the first tick is 8 cycles later.

Source files
------------

// File: rtl/scroll_rate_ctrl.sv
// scroll_rate_ctrl: run-time adjustable scroll strobe for the 7-segment message display.
// Two debounced pushbuttons halve or double the scroll period.
// A pause input freezes the period counter.
module scroll_rate_ctrl #(
  parameter int unsigned MIN_PERIOD      = 3125000,
  parameter int unsigned NUM_LEVELS      = 8,
  parameter int unsigned DEFAULT_LEVEL   = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 32
) (
  input  logic                          CLOCK_50,
  input  logic                          Resetn,
  input  logic                          faster_n,
  input  logic                          slower_n,
  input  logic                          pause,
  output logic                          tick,
  output logic [$clog2(NUM_LEVELS)-1:0] level
);

  localparam int unsigned LvlW = $clog2(NUM_LEVELS);
  localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [LvlW-1:0]  MaxLevel = LvlW'(NUM_LEVELS - 1);
  localparam logic [LvlW-1:0]  RstLevel = LvlW'(DEFAULT_LEVEL);
  localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MinPer   = CNT_W'(MIN_PERIOD);

  // Button vectors: bit 0 is the faster button, bit 1 is the slower button.
  logic [1:0]          btn_raw;
  logic [1:0]          sync1_q, sync2_q;
  logic [1:0]          stable_q, stable_d;
  logic [1:0]          press_q, press_d;
  logic [1:0][DbW-1:0] db_cnt_q, db_cnt_d;

  logic [LvlW-1:0]  level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_last;
  logic             tick_q, tick_d;
  logic             restart;

  assign btn_raw = {slower_n, faster_n};

  // Two-flop synchronizers, debounce state and the registered press pulses.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      sync1_q  <= 2'b11;
      sync2_q  <= 2'b11;
      stable_q <= 2'b11;
      press_q  <= 2'b00;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Debounce: accept a new button level only after it has persisted DEBOUNCE_CYCLES cycles.
  always_comb begin
    stable_d = stable_q;
    press_d  = 2'b00;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          stable_d[i] = sync2_q[i];
          db_cnt_d[i] = '0;
          // Pulse only on the 1->0 (press) transition; release is silent.
          press_d[i]  = stable_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
  end

  // Level, period counter and tick registers.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      level_q <= RstLevel;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
    end
  end

  // Level update on press pulses; period counting with restart taking priority over the wrap.
  always_comb begin
    level_d     = level_q;
    cnt_d       = cnt_q;
    tick_d      = 1'b0;
    restart     = 1'b0;
    period_last = (MinPer << level_q) - CNT_W'(1);

    // Simultaneous presses cancel; saturated presses change nothing and do not restart.
    if (press_q[0] && !press_q[1] && (level_q != '0)) begin
      level_d = level_q - LvlW'(1);
      restart = 1'b1;
    end else if (press_q[1] && !press_q[0] && (level_q != MaxLevel)) begin
      level_d = level_q + LvlW'(1);
      restart = 1'b1;
    end

    if (restart) begin
      cnt_d = '0;
    end else if (!pause) begin
      if (cnt_q == period_last) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign tick  = tick_q;
  assign level = level_q;

endmodule
